// File: rtl/handshake_tx_if.sv
// handshake_tx_if: push side, req/ack handshake and status of the handshake_tx stage
interface handshake_tx_if #(parameter int DATA_W = 8);
    logic              validdata;
    logic [DATA_W-1:0] data_in;
    logic              acknowledge;
    logic              req;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              busy;
    logic              overflow;
    logic              timeout_err;
    logic [7:0]        sent_count;
    modport master (
        output validdata, data_in, acknowledge,
        input  req, data_out, full, busy, overflow, timeout_err, sent_count
    );
    modport slave (
        input  validdata, data_in, acknowledge,
        output req, data_out, full, busy, overflow, timeout_err, sent_count
    );
endinterface

// File: rtl/handshake_tx.sv
// handshake_tx: FIFO-buffered req/acknowledge transmitter with wait timeout and gap cycle
module handshake_tx #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst,
    handshake_tx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [AW:0]       r_count;
    logic [1:0]        r_state;
    logic [CW-1:0]     r_wait;
    logic              r_req, r_ovf, r_tmo;
    logic [DATA_W-1:0] r_data;
    logic [7:0]        r_sent;
    logic              w_full, w_pop, w_push;
    // IDLE decides on the registered count, so a word pushed this edge waits one more
    assign w_full = r_count == (AW+1)'(DEPTH);
    assign w_pop  = r_state == IDLE && r_count != '0;
    assign w_push = bus.validdata && (!w_full || w_pop);
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= bus.data_in;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_state <= IDLE;
            r_wait  <= '0;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_tmo   <= 1'b0;
            r_sent  <= '0;
        end else begin
            r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (bus.validdata && !w_push) r_ovf <= 1'b1;
            if (r_state == IDLE) begin
                if (w_pop) begin
                    r_data  <= r_mem[r_rd];
                    r_req   <= 1'b1;
                    r_wait  <= '0;
                    r_state <= REQ;
                end
            end else if (r_state == REQ) begin
                if (bus.acknowledge) begin
                    r_req   <= 1'b0;
                    r_sent  <= r_sent + 8'd1;
                    r_state <= GAP;
                end else if (r_wait == CW'(TIMEOUT - 1)) begin
                    r_req   <= 1'b0;
                    r_tmo   <= 1'b1;
                    r_state <= GAP;
                end else begin
                    r_wait  <= r_wait + 1'b1;
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end
    assign bus.req         = r_req;
    assign bus.data_out    = r_data;
    assign bus.full        = w_full;
    assign bus.busy        = r_state != IDLE || r_count != '0;
    assign bus.overflow    = r_ovf;
    assign bus.timeout_err = r_tmo;
    assign bus.sent_count  = r_sent;
endmodule
